// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: port indices, FSM encoding and defaults shared by the data-memory arbiter
package dmem_arbiter_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam int DEF_MAX_LOCK = 15;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: grant selection; round-robin ties when DMEM_ARB_RR_EN is defined, else port 0 wins
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] state_i,
  input  logic       last_i,
  input  logic       handoff_i,
  output logic [1:0] gnt_o
);
  logic pref;
`ifdef DMEM_ARB_RR_EN
  assign pref = ~last_i;
`else
  // after a forced release the previous owner yields one tie
  assign pref = handoff_i & ~last_i;
`endif
  always_comb
    gnt_o = state_i == ST_OWN0 ? {1'b0, req_i[PORT_CPU]}
          : state_i == ST_OWN1 ? {req_i[PORT_AUX], 1'b0}
          : &req_i ? (pref ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter with lock ownership and forced release.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [7:0] MAX = 8'(MAX_LOCK);
  logic [1:0] state_q, state_d, pick, gnt, rvalid_q;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc;
  logic last_q, last_d, hand_q, hand_d;
  logic we_sel, lock_sel, own, lock_own, sat;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  dmem_arb_pick u_pick (
    .req_i    ({req1, req0}),
    .state_i  (state_q),
    .last_i   (last_q),
    .handoff_i(hand_q),
    .gnt_o    (pick)
  );
  assign gnt       = reset ? 2'b00 : pick;
  assign gnt0      = gnt[PORT_CPU];
  assign gnt1      = gnt[PORT_AUX];
  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign we_sel    = gnt1 ? we1 : we0;
  assign lock_sel  = gnt1 ? lock1 : lock0;
  assign mem_read  = |gnt & ~we_sel;
  assign mem_write = |gnt & we_sel;
  assign own       = state_q == ST_OWN1;
  assign lock_own  = own ? lock1 : lock0;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign sat       = cnt_inc >= {1'b0, MAX};
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    hand_d  = |gnt ? 1'b0 : hand_q;
`ifdef DMEM_ARB_RR_EN
    last_d  = |gnt ? gnt1 : last_q;
`endif
    if (state_q == ST_IDLE) begin
      if (|gnt && lock_sel) begin
        state_d = gnt1 ? ST_OWN1 : ST_OWN0;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = sat ? MAX : cnt_inc[7:0];
      if (!lock_own) state_d = ST_IDLE;
      else if (sat) begin
        state_d = ST_IDLE;
        last_d  = own;
        hand_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      hand_q   <= 1'b0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      hand_q   <= hand_d;
      rvalid_q <= gnt & {~we1, ~we0};
      if (gnt0 && !we0) rdata0_q <= mem_rdata;
      if (gnt1 && !we1) rdata1_q <= mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed scoreboard bench against an ownership/queue reference model
module tb_dmem_arbiter;
  localparam int MAXL = 15;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] q0 [$], q1 [$];
  int n_cmp = 0, n_bad = 0;
  int owner = -1, held = 0;
  logic last = 1'b1, hand = 1'b0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rs,
                      input logic r0, input logic w0, input logic l0, input logic [7:0] i0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1, input logic [7:0] i1, input logic [31:0] d1);
    logic e0, e1, pref, p, wr;
    @(negedge clk);
    reset = rs;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = {22'd0, i0, 2'd0}; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = {22'd0, i1, 2'd0}; wdata1 = d1;
    pref = RR ? ~last : (hand & ~last);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rs) begin
      if (owner == 0) e0 = r0;
      else if (owner == 1) e1 = r1;
      else if (r0 && r1) begin e0 = ~pref; e1 = pref; end
      else begin e0 = r0; e1 = r1; end
    end
    p  = e1;
    wr = p ? w1 : w0;
    #2;
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    chk("mem_read", mem_read, (e0 | e1) & ~wr);
    chk("mem_write", mem_write, (e0 | e1) & wr);
    chk("mem_addr", mem_addr, p ? addr1 : addr0);
    if ((e0 | e1) && wr) chk("mem_wdata", mem_wdata, p ? d1 : d0);
    if (rs) begin
      owner = -1; held = 0; last = 1'b1; hand = 1'b0;
    end else begin
      if (e0 | e1) begin
        if (wr) shadow[p ? i1 : i0] = p ? d1 : d0;
        else if (p) q1.push_back(shadow[i1]);
        else q0.push_back(shadow[i0]);
        if (RR) last = p;
        hand = 1'b0;
      end
      if (owner < 0) begin
        if ((e0 && l0) || (e1 && l1)) begin owner = p ? 1 : 0; held = 0; end
      end else begin
        held++;
        if (!(owner == 1 ? l1 : l0)) owner = -1;
        else if (held == MAXL) begin last = (owner == 1); hand = 1'b1; owner = -1; end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("rvalid0", rvalid0, q0.size() != 0);
    if (rvalid0 && q0.size() != 0) chk("rdata0", rdata0, q0[0]);
    if (q0.size() != 0) void'(q0.pop_front());
    chk("rvalid1", rvalid1, q1.size() != 0);
    if (rvalid1 && q1.size() != 0) chk("rdata1", rdata1, q1[0]);
    if (q1.size() != 0) void'(q1.pop_front());
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(100 + i);
      shadow[i] = 32'(100 + i);
    end
    step('1, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    step('1, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    chk("rdata0_rst", rdata0, 32'h0);
    chk("rdata1_rst", rdata1, 32'h0);
    // first read of address 0 returns its initial content
    step('0, '1,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    repeat (6) step('0, '1,'0,'0,8'h01,32'h0, '1,'0,'0,8'h02,32'h0);
    // port 1 locked write, locked readback, then release while port 0 waits
    step('0, '0,'0,'0,8'h00,32'h0, '1,'1,'1,8'h04,32'hDEADBEEF);
    step('0, '1,'0,'0,8'h04,32'h0, '1,'0,'1,8'h04,32'h0);
    step('0, '1,'0,'0,8'h04,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '1,'0,'0,8'h04,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    // port 1 never drops its lock: forced release
    step('0, '0,'0,'0,8'h00,32'h0, '1,'1,'1,8'h08,32'h1234);
    repeat (20) step('0, '1,'0,'0,8'h08,32'h0, '1,'0,'1,8'h09,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    // reset during requests: no grant, write not committed
    step('0, '1,'0,'0,8'h03,32'h0, '0,'0,'0,8'h00,32'h0);
    step('1, '1,'0,'0,8'h03,32'h0, '1,'1,'0,8'h05,32'hBAD0BAD0);
    step('0, '0,'0,'0,8'h00,32'h0, '1,'0,'0,8'h05,32'h0);
    // owner 0 drops req while holding the lock
    step('0, '1,'0,'1,8'h06,32'h0, '0,'0,'0,8'h00,32'h0);
    repeat (3) step('0, '0,'0,'1,8'h00,32'h0, '1,'1,'0,8'h07,32'h77);
    step('0, '0,'0,'0,8'h00,32'h0, '1,'1,'0,8'h07,32'h77);
    step('0, '0,'0,'0,8'h00,32'h0, '1,'0,'0,8'h07,32'h0);
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), $urandom);
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, 8'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0, 8'($urandom_range(0, 15)), $urandom);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    step('0, '0,'0,'0,8'h00,32'h0, '0,'0,'0,8'h00,32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
